serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. It accepts two WIDTH-bit operands and a carry-in through a start/done handshake, then drives one internal 1-bit full-add cell LSB-first for WIDTH cycles. It holds the running carry in a flop and assembles the sum in a shift register. It time-shares a single full-adder cell across all bit positions, so it replaces a WIDTH-bit ripple adder where area matters more than latency.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when accepted (see Behaviour).
a  input  WIDTH  operand A; latched on accept.
b  input  WIDTH  operand B; latched on accept.
cin  input  1  carry-in; latched on accept.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse; sum/cout valid.
sum  output  WIDTH  result; held until next accept.
cout  output  1  final carry; held until next accept.

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE; busy=0, done=0, sum=0, cout=0; carry flop=0; counter=0; operand regs=0. Any in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 at an edge is accepted: latch a, b; carry<=cin; counter<=0; go to RUN.
- RUN: busy=1, done=0.
  - Each edge: s=a_r[0]^b_r[0]^carry; carry<=maj(a_r[0],b_r[0],carry); shift a_r, b_r right by 1; shift s into the MSB of the sum shift register; counter++.
  - After the WIDTH-th RUN edge (counter reaches WIDTH), go to DONE.
  - start is ignored in RUN: no re-latch, no error.
- DONE: busy=0, done=1 for exactly one cycle. sum holds the full WIDTH-bit result; cout equals the final carry.
  - Next edge: if start=1, accept it (same as IDLE) and go to RUN. Otherwise go to IDLE.
  - Back-to-back operations therefore have no idle bubble.
- Latency: accept edge at cycle 0 → done high during cycle WIDTH+1. Throughput: one result per WIDTH+1 cycles.
- sum/cout are registered outputs. They change only while RUN is shifting and at reset. Internal partial sums are visible on sum during RUN; consumers qualify sum with done.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts exactly one cycle.

Optional Feature:
SERIAL_ADD_SUB_EN.
- Defined: adds input port sub (1 bit), latched on accept.
  - sub=1: b is latched inverted and cin is ignored (carry forced to 1), giving sum = a − b mod 2^WIDTH; cout=1 means no borrow (a ≥ b unsigned).
  - sub=0: identical to the base behaviour.
- Undefined: no sub port; addition only. Gate count and timing are identical to the base block.

Test Plan:
- WIDTH=1, all 8 combinations of {a,b,cin}, each via start → {cout,sum} matches the full-adder truth table; done arrives 2 cycles after accept.
- WIDTH=8: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 → sum=0x00, cout=0. done pulses once per op, 9 cycles after each accept.
- Start held high through RUN with changing a/b → operands from the accept edge only are used; result a=0x12 + b=0x34 = 0x46 unchanged by later inputs.
- Start asserted in the DONE cycle with a=0x80, b=0x80, cin=0 → accepted with no IDLE cycle; next done shows sum=0x00, cout=1, 9 cycles later.
- rst pulsed at RUN cycle 4 → busy, done, sum and cout are 0 immediately (async). No done pulse follows. A subsequent start completes normally.
- With SERIAL_ADD_SUB_EN, sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0. Then a=0x07, b=0x05 → sum=0x02, cout=1.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/done handshake and operand/result bus of the bit-serial adder; SERIAL_ADD_SUB_EN adds sub.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );
  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer, one full-add cell time-shared LSB-first; SERIAL_ADD_SUB_EN enables subtract.
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave io
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s, c_nxt, b_inv, c_init;
`ifdef SERIAL_ADD_SUB_EN
  assign b_inv  = io.sub;
  assign c_init = io.sub | io.cin;
`else
  assign b_inv  = 1'b0;
  assign c_init = io.cin;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    s       = a_q[0] ^ b_q[0] ^ carry_q;
    c_nxt   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      sum_d   = WIDTH'({s, sum_q} >> 1);
      carry_d = c_nxt;
      cout_d  = c_nxt;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? DONE : RUN;
    end else if (io.start) begin
      a_d     = io.a;
      b_d     = b_inv ? ~io.b : io.b;
      carry_d = c_init;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end
  assign io.busy = (state_q == RUN);
  assign io.done = (state_q == DONE);
  assign io.sum  = sum_q;
  assign io.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed table-driven bench for WIDTH=1 and WIDTH=8 instances of serial_add_ctrl.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic sub_v = 1'b0;
  always #5 clk = ~clk;
  serial_add_ctrl_if #(.WIDTH(1)) i1 ();
  serial_add_ctrl_if #(.WIDTH(8)) i8 ();
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .io(i1.slave));
  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .io(i8.slave));
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;
  vec_t tv[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output logic [7:0] s, output logic co, output int lat);
    @(negedge clk);
    i8.start = 1'b1;
    i8.a = a;
    i8.b = b;
    i8.cin = c;
`ifdef SERIAL_ADD_SUB_EN
    i8.sub = sub_v;
`endif
    @(posedge clk);
    #1 i8.start = 1'b0;
    lat = 1;
    while (!i8.done && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    s = i8.sum;
    co = i8.cout;
  endtask
  task automatic op1(input logic a, input logic b, input logic c,
                     output logic s, output logic co, output int lat);
    @(negedge clk);
    i1.start = 1'b1;
    i1.a = a;
    i1.b = b;
    i1.cin = c;
    @(posedge clk);
    #1 i1.start = 1'b0;
    lat = 1;
    while (!i1.done && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    s = i1.sum;
    co = i1.cout;
  endtask
  initial begin
    logic [7:0] s8;
    logic       s1, co;
    logic [1:0] exp2;
    int         lat, dones;
    tv[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tv[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tv[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tv[3] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};
    i1.start = 0; i1.a = 0; i1.b = 0; i1.cin = 0;
    i8.start = 0; i8.a = 0; i8.b = 0; i8.cin = 0;
`ifdef SERIAL_ADD_SUB_EN
    i1.sub = 0; i8.sub = 0;
`endif
    repeat (2) @(posedge clk);
    #1 chk("reset_busy", 32'(i8.busy), 0);
    chk("reset_done", 32'(i8.done), 0);
    chk("reset_sum_cout", {23'd0, i8.cout, i8.sum}, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0], s1, co, lat);
      exp2 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      chk($sformatf("w1_fa%0d", i), {co, s1}, 32'(exp2));
      chk($sformatf("w1_lat%0d", i), lat, 2);
    end
    for (int i = 0; i < 4; i++) begin
      op8(tv[i].a, tv[i].b, tv[i].cin, s8, co, lat);
      chk($sformatf("w8_vec%0d", i), {co, s8}, {tv[i].cout, tv[i].sum});
      chk($sformatf("w8_lat%0d", i), lat, 9);
      @(posedge clk);
      #1 chk($sformatf("w8_pulse%0d", i), {i8.busy, i8.done}, 0);
    end
    @(negedge clk);
    i8.start = 1; i8.a = 8'h12; i8.b = 8'h34; i8.cin = 0;
    @(posedge clk);
    lat = 1;
    #1;
    while (!i8.done && lat < 20) begin
      @(negedge clk);
      i8.a = 8'($urandom); i8.b = 8'($urandom); i8.cin = 1'($urandom);
      @(posedge clk);
      #1 lat++;
    end
    i8.start = 0;
    chk("hold_start_sum", {i8.cout, i8.sum}, 9'h046);
    chk("hold_start_lat", lat, 9);
    op8(8'h11, 8'h22, 1'b0, s8, co, lat);
    chk("b2b_first", {co, s8}, 9'h033);
    i8.start = 1; i8.a = 8'h80; i8.b = 8'h80; i8.cin = 0;
    @(posedge clk);
    #1 i8.start = 0;
    chk("b2b_no_bubble", {i8.busy, i8.done}, 2'b10);
    lat = 1;
    while (!i8.done && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("b2b_second", {i8.cout, i8.sum}, 9'h100);
    chk("b2b_lat", lat, 9);
    @(negedge clk);
    i8.start = 1; i8.a = 8'hFF; i8.b = 8'hFF; i8.cin = 1;
    @(posedge clk);
    #1 i8.start = 0;
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_sum", 32'(i8.sum != 0), 1);
    #1 rst = 1'b1;
    #1 chk("rst_async", {i8.busy, i8.done, i8.cout, i8.sum}, 0);
    @(negedge clk) rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (i8.done) dones++;
    end
    chk("rst_no_done", dones, 0);
    op8(8'h0F, 8'hF0, 1'b1, s8, co, lat);
    chk("post_rst_op", {co, s8}, 9'h100);
    chk("post_rst_lat", lat, 9);
`ifdef SERIAL_ADD_SUB_EN
    sub_v = 1'b1;
    op8(8'h05, 8'h07, 1'b0, s8, co, lat);
    chk("sub_5_7", {co, s8}, 9'h0FE);
    op8(8'h07, 8'h05, 1'b0, s8, co, lat);
    chk("sub_7_5", {co, s8}, 9'h102);
    sub_v = 1'b0;
    op8(8'h07, 8'h05, 1'b1, s8, co, lat);
    chk("sub0_add", {co, s8}, 9'h00D);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
